// File: rtl/alu_mc_pkg.sv
// Shared widths, opcode values and FSM state encoding for the multi-cycle ALU.
package alu_mc_pkg;

  localparam int DATA_W     = 32;
  localparam int OPRN_W     = 6;
  localparam int MUL_CYCLES = DATA_W;
  localparam int CNT_W      = $clog2(MUL_CYCLES + 1);

  // Shift amounts at or above this value flush the operand to zero.
  localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

  typedef enum logic [OPRN_W-1:0] {
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_MUL = 6'd3,
    OP_SHR = 6'd4,
    OP_SHL = 6'd5,
    OP_AND = 6'd6,
    OP_OR  = 6'd7,
    OP_NOR = 6'd8,
    OP_SLT = 6'd9
  } oprn_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response handshake bundle between an initiator and the ALU.
interface alu_mc_if;
  import alu_mc_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [OPRN_W-1:0] oprn;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] out;
  logic              zero;

  modport master (
    output req_valid, op1, op2, oprn, rsp_ready,
    input  req_ready, rsp_valid, out, zero
  );

  modport slave (
    input  req_valid, op1, op2, oprn, rsp_ready,
    output req_ready, rsp_valid, out, zero
  );

endinterface

// File: rtl/alu_mc_mult32_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low DATA_W product bits.
module mult32_seq
  import alu_mc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] mcand_reg;
  logic [DATA_W-1:0] mplier_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= multiplicand;
      mplier_reg <= multiplier;
      acc_reg    <= '0;
      cnt_reg    <= CNT_W'(MUL_CYCLES);
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      if (cnt_reg != '0) begin
        if (mplier_reg[0]) begin
          acc_reg <= acc_reg + mcand_reg;
        end
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg - CNT_W'(1);
      end else begin
        // done is visible for exactly one cycle before the unit goes quiet
        busy_reg <= 1'b0;
      end
    end
  end

  assign done    = busy_reg && (cnt_reg == '0);
  assign product = acc_reg;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready request and response handshakes.
module alu_mc
  import alu_mc_pkg::*;
(
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);

  state_e            state_reg;
  logic [DATA_W-1:0] op1_reg;
  logic [DATA_W-1:0] op2_reg;
  logic [OPRN_W-1:0] oprn_reg;
  logic [DATA_W-1:0] out_reg;
  logic              zero_reg;
  logic              rsp_valid_reg;

  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] single_result;

  assign bus.req_ready = (state_reg == ST_IDLE) && rst_n;
  assign accept        = bus.req_valid && bus.req_ready;
  // The multiplier loads straight from the bus so iterations begin on the first EXEC cycle.
  assign mul_start     = accept && (bus.oprn == OP_MUL);

  mult32_seq u_mult (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .multiplicand (bus.op1),
    .multiplier   (bus.op2),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_comb begin
    single_result = '0;
    case (oprn_reg)
      OP_ADD: single_result = op1_reg + op2_reg;
      OP_SUB: single_result = op1_reg - op2_reg;
      OP_SHR: single_result = (op2_reg >= SHIFT_LIMIT) ? '0 : (op1_reg >> op2_reg);
      OP_SHL: single_result = (op2_reg >= SHIFT_LIMIT) ? '0 : (op1_reg << op2_reg);
      OP_AND: single_result = op1_reg & op2_reg;
      OP_OR:  single_result = op1_reg | op2_reg;
      OP_NOR: single_result = ~(op1_reg | op2_reg);
      OP_SLT: single_result = {{(DATA_W-1){1'b0}}, ($signed(op1_reg) < $signed(op2_reg))};
      default: single_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      op1_reg       <= '0;
      op2_reg       <= '0;
      oprn_reg      <= '0;
      out_reg       <= '0;
      zero_reg      <= 1'b1;
      rsp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op1_reg   <= bus.op1;
            op2_reg   <= bus.op2;
            oprn_reg  <= bus.oprn;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (oprn_reg == OP_MUL) begin
            if (mul_done) begin
              out_reg       <= mul_product;
              zero_reg      <= (mul_product == '0);
              rsp_valid_reg <= 1'b1;
              state_reg     <= ST_DONE;
            end
          end else begin
            out_reg       <= single_result;
            zero_reg      <= (single_result == '0);
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.out       = out_reg;
  assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus randomized ops against a behavioural model.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if bus ();

  alu_mc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned full;
    if (op == 1) return a + b;
    if (op == 2) return a - b;
    if (op == 3) begin
      full = longint'(a) * longint'(b);
      return full[31:0];
    end
    if (op == 4) return (b >= 32) ? 32'd0 : a >> b;
    if (op == 5) return (b >= 32) ? 32'd0 : a << b;
    if (op == 6) return a & b;
    if (op == 7) return a | b;
    if (op == 8) return ~(a | b);
    if (op == 9) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit intrude, input bit early,
                       output logic [31:0] res);
    int          lat;
    int          exp_lat;
    bit          busy_ready;
    bit          unstable;
    logic [31:0] exp;
    exp     = model(op, a, b);
    exp_lat = (op == 3) ? 33 : 1;
    @(negedge clk);
    check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.op1       = a;
    bus.op2       = b;
    bus.oprn      = 6'(op);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.op1       = $urandom;
    bus.op2       = $urandom;
    bus.oprn      = 6'($urandom_range(0, 12));
    bus.rsp_ready = early;
    lat           = 0;
    busy_ready    = 1'b0;
    while (!bus.rsp_valid && lat < 100) begin
      if (bus.req_ready) busy_ready = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("ready_busy", {31'b0, busy_ready}, 32'd0);
    check("ready_done", {31'b0, bus.req_ready}, 32'd0);
    check("out", bus.out, exp);
    check("zero", {31'b0, bus.zero}, {31'b0, (exp == 32'd0)});
    res      = bus.out;
    unstable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (intrude) begin
        bus.req_valid = 1'b1;
        bus.oprn      = 6'(1);
        bus.op1       = $urandom;
        bus.op2       = $urandom;
      end
      @(posedge clk);
      #1;
      if (!bus.rsp_valid || bus.out !== res || bus.zero !== (res == 32'd0) || bus.req_ready)
        unstable = 1'b1;
    end
    if (hold > 0) check("hold_stable", {31'b0, unstable}, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("rsp_drop", {31'b0, bus.rsp_valid}, 32'd0);
    check("ready_after", {31'b0, bus.req_ready}, 32'd1);
    $display("op=%0d a=%h b=%h out=%h exp=%h lat=%0d hold=%0d", op, a, b, res, exp, lat, hold);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    bit          intrude;
    bit          early;
    bit          leaked;

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.oprn      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_out", bus.out, 32'd0);
    check("rst_zero", {31'b0, bus.zero}, 32'd1);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1, 32'd10, 32'd15, 0, 1'b0, 1'b0, r);   check("add_10_15", r, 32'd25);
    do_op(3, -15, 32'd42, 0, 1'b0, 1'b0, r);      check("mul_m15_42", r, 32'hFFFF_FD8A);
    do_op(2, -30, -30, 0, 1'b0, 1'b0, r);         check("sub_eq", r, 32'd0);
    do_op(9, -15, 32'd42, 0, 1'b0, 1'b0, r);      check("slt_neg", r, 32'd1);
    do_op(9, 32'd23, 32'd0, 0, 1'b0, 1'b0, r);    check("slt_pos", r, 32'd0);
    do_op(8, 32'd0, 32'd0, 0, 1'b0, 1'b0, r);     check("nor_zero", r, 32'hFFFF_FFFF);
    do_op(1, 32'd25, -25, 5, 1'b1, 1'b0, r);      check("add_hold", r, 32'd0);

    // abort a multiply at iteration 10; nothing may come out afterwards
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op1       = 32'd7;
    bus.op2       = 32'd9;
    bus.oprn      = 6'(3);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("abort_out", bus.out, 32'd0);
    check("abort_zero", {31'b0, bus.zero}, 32'd1);
    check("abort_req_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    leaked = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid || !bus.req_ready) leaked = 1'b1;
    end
    check("abort_no_partial", {31'b0, leaked}, 32'd0);
    $display("reset abort during mul: rsp_valid=%0b out=%h", bus.rsp_valid, bus.out);

    do_op(3, 32'd10, 32'd10, 0, 1'b0, 1'b0, r);   check("mul_10_10", r, 32'd100);
    do_op(5, 32'd1, 32'd32, 0, 1'b0, 1'b0, r);    check("shl_32", r, 32'd0);
    do_op(4, -15, 32'd15, 0, 1'b0, 1'b0, r);      check("shr_15", r, 32'h0001_FFFF);
    do_op(0, 32'd5, 32'd7, 0, 1'b0, 1'b0, r);     check("illegal_op", r, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op      = int'($urandom_range(0, 11));
      a       = $urandom;
      b       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      hold    = int'($urandom_range(0, 3));
      intrude = 1'($urandom_range(0, 1));
      early   = (hold == 0) && ($urandom_range(0, 1) == 1);
      do_op(op, a, b, hold, intrude, early, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
